// File: rtl/hc_tx_port_arbiter_pkg.sv
// Shared definitions for the host-controller SIE Tx port arbiter: state encodings,
// requester indices, hold-timeout default and the SIE Tx control codes.
package hc_tx_port_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GNT_SOF    = 3'd1,
    GNT_SP     = 3'd2,
    GNT_DC     = 3'd3,
    TURNAROUND = 3'd4
  } txArbState_t;

  // Bit positions of each requester in the req/grant/rdy vectors
  localparam int unsigned REQ_SOF = 0;
  localparam int unsigned REQ_SP  = 1;
  localparam int unsigned REQ_DC  = 2;
  localparam int unsigned NUM_REQ = 3;

  localparam logic [15:0] MAX_HOLD_DEFAULT = 16'd2048;

  // SIE Tx control codes
  localparam logic [7:0] TX_PACKET_START   = 8'h00;
  localparam logic [7:0] TX_PACKET_STREAM  = 8'h01;
  localparam logic [7:0] TX_LINE_CONTROL   = 8'h02;
  localparam logic [7:0] TX_DIRECT_CONTROL = 8'h03;
  localparam logic [7:0] TX_RESUME_START   = 8'h04;

endpackage

// File: rtl/hc_tx_port_mux.sv
// Combinational 3:1 mux onto the SIE Tx port, steered by a one-hot grant vector.
// Nothing reaches the port and no ready is returned while no requester is granted.
module hc_tx_port_mux
  import hc_tx_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] gntVec,
  input  logic [7:0]         sofCntl,
  input  logic [7:0]         sofData,
  input  logic               sofWEn,
  input  logic [7:0]         spCntl,
  input  logic [7:0]         spData,
  input  logic               spWEn,
  input  logic [7:0]         dcCntl,
  input  logic [7:0]         dcData,
  input  logic               dcWEn,
  input  logic               portRdy,
  output logic [7:0]         portCntl,
  output logic [7:0]         portData,
  output logic               portWEn,
  output logic [NUM_REQ-1:0] rdyVec
);

  always_comb begin
    portCntl = 8'h00;
    portData = 8'h00;
    portWEn  = 1'b0;
    rdyVec   = '0;
    unique case (gntVec)
      3'b001: begin
        portCntl        = sofCntl;
        portData        = sofData;
        portWEn         = sofWEn;
        rdyVec[REQ_SOF] = portRdy;
      end
      3'b010: begin
        portCntl       = spCntl;
        portData       = spData;
        portWEn        = spWEn;
        rdyVec[REQ_SP] = portRdy;
      end
      3'b100: begin
        portCntl       = dcCntl;
        portData       = dcData;
        portWEn        = dcWEn;
        rdyVec[REQ_DC] = portRdy;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hc_tx_port_arbiter.sv
// Fixed-priority (SOF > SP > DC), non-preemptive arbiter for the SIE Tx port with a
// hold-timeout watchdog that reclaims the port from a requester that stops writing.
module hc_tx_port_arbiter
  import hc_tx_port_arbiter_pkg::*;
#(
  parameter logic [15:0] MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SOFTxReq,
  output logic       SOFTxGnt,
  input  logic [7:0] SOFTxCntl,
  input  logic [7:0] SOFTxData,
  input  logic       SOFTxWEn,
  output logic       SOFTxRdy,
  input  logic       SPTxReq,
  output logic       SPTxGnt,
  input  logic [7:0] SPTxCntl,
  input  logic [7:0] SPTxData,
  input  logic       SPTxWEn,
  output logic       SPTxRdy,
  input  logic       DCTxReq,
  output logic       DCTxGnt,
  input  logic [7:0] DCTxCntl,
  input  logic [7:0] DCTxData,
  input  logic       DCTxWEn,
  output logic       DCTxRdy,
  output logic [7:0] TxPortCntl,
  output logic [7:0] TxPortData,
  output logic       TxPortWEn,
  input  logic       TxPortRdy,
  output logic       HoldTimeout
);

  txArbState_t        stateQ, stateD;
  logic [15:0]        holdCntQ, holdCntD, holdCntInc;
  logic [NUM_REQ-1:0] maskQ, maskD;
  logic [NUM_REQ-1:0] reqVec, eligible, gntVec, rdyVec;
  logic               timeoutQ, timeoutD;
  logic               gntReq;

  assign reqVec   = {DCTxReq, SPTxReq, SOFTxReq};
  assign eligible = reqVec & ~maskQ;

  always_comb begin
    gntVec = '0;
    unique case (stateQ)
      GNT_SOF: gntVec[REQ_SOF] = 1'b1;
      GNT_SP:  gntVec[REQ_SP]  = 1'b1;
      GNT_DC:  gntVec[REQ_DC]  = 1'b1;
      default: ;
    endcase
  end

  assign gntReq     = |(reqVec & gntVec);
  assign holdCntInc = (holdCntQ == 16'hFFFF) ? holdCntQ : holdCntQ + 16'd1;

  always_comb begin
    stateD   = stateQ;
    holdCntD = holdCntQ;
    // A mask drops as soon as its requester is seen with req low
    maskD    = maskQ & reqVec;
    timeoutD = 1'b0;
    unique case (stateQ)
      IDLE: begin
        holdCntD = '0;
        if (eligible[REQ_SOF])     stateD = GNT_SOF;
        else if (eligible[REQ_SP]) stateD = GNT_SP;
        else if (eligible[REQ_DC]) stateD = GNT_DC;
      end
      GNT_SOF, GNT_SP, GNT_DC: begin
        // A req drop wins over a coincident timeout: plain release, no pulse
        if (!gntReq) begin
          stateD = TURNAROUND;
        end else if (TxPortWEn) begin
          holdCntD = '0;
        end else begin
          holdCntD = holdCntInc;
          if (holdCntInc >= MAX_HOLD) begin
            stateD   = TURNAROUND;
            timeoutD = 1'b1;
            maskD    = (maskQ & reqVec) | gntVec;
          end
        end
      end
      TURNAROUND: stateD = IDLE;
      default:    stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= IDLE;
      holdCntQ <= '0;
      maskQ    <= '0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      holdCntQ <= holdCntD;
      maskQ    <= maskD;
      timeoutQ <= timeoutD;
    end
  end

  hc_tx_port_mux u_mux (
    .gntVec   (gntVec),
    .sofCntl  (SOFTxCntl),
    .sofData  (SOFTxData),
    .sofWEn   (SOFTxWEn),
    .spCntl   (SPTxCntl),
    .spData   (SPTxData),
    .spWEn    (SPTxWEn),
    .dcCntl   (DCTxCntl),
    .dcData   (DCTxData),
    .dcWEn    (DCTxWEn),
    .portRdy  (TxPortRdy),
    .portCntl (TxPortCntl),
    .portData (TxPortData),
    .portWEn  (TxPortWEn),
    .rdyVec   (rdyVec)
  );

  assign SOFTxGnt    = gntVec[REQ_SOF];
  assign SPTxGnt     = gntVec[REQ_SP];
  assign DCTxGnt     = gntVec[REQ_DC];
  assign SOFTxRdy    = rdyVec[REQ_SOF];
  assign SPTxRdy     = rdyVec[REQ_SP];
  assign DCTxRdy     = rdyVec[REQ_DC];
  assign HoldTimeout = timeoutQ;

endmodule

// File: tb/tb_hc_tx_port_arbiter.sv
// Directed scoreboard bench for hc_tx_port_arbiter (MAX_HOLD = 8): each stimulus cycle
// queues its hand-computed expected outputs, a monitor compares them mid-cycle.
module tb_hc_tx_port_arbiter;
  import hc_tx_port_arbiter_pkg::*;

  localparam logic [7:0] SPC = 8'h5A;
  localparam logic [7:0] SPD = 8'h3C;
  localparam logic [7:0] DCC = 8'hC3;
  localparam logic [7:0] DCD = 8'hA5;
  localparam logic [7:0] SC  = TX_RESUME_START;

  // gnt/rdy vectors are {DC, SP, SOF}
  typedef struct packed {
    logic [2:0] gnt;
    logic [2:0] rdy;
    logic [7:0] cntl;
    logic [7:0] data;
    logic       wen;
    logic       to;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic SOFTxReq, SOFTxGnt, SOFTxWEn, SOFTxRdy;
  logic SPTxReq, SPTxGnt, SPTxWEn, SPTxRdy;
  logic DCTxReq, DCTxGnt, DCTxWEn, DCTxRdy;
  logic [7:0] SOFTxCntl, SOFTxData, SPTxCntl, SPTxData, DCTxCntl, DCTxData;
  logic [7:0] TxPortCntl, TxPortData;
  logic TxPortWEn, TxPortRdy, HoldTimeout;

  obs_t  expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    errors = 0;

  hc_tx_port_arbiter #(.MAX_HOLD(16'd8)) dut (
    .clk         (clk),
    .rst         (rst),
    .SOFTxReq    (SOFTxReq),
    .SOFTxGnt    (SOFTxGnt),
    .SOFTxCntl   (SOFTxCntl),
    .SOFTxData   (SOFTxData),
    .SOFTxWEn    (SOFTxWEn),
    .SOFTxRdy    (SOFTxRdy),
    .SPTxReq     (SPTxReq),
    .SPTxGnt     (SPTxGnt),
    .SPTxCntl    (SPTxCntl),
    .SPTxData    (SPTxData),
    .SPTxWEn     (SPTxWEn),
    .SPTxRdy     (SPTxRdy),
    .DCTxReq     (DCTxReq),
    .DCTxGnt     (DCTxGnt),
    .DCTxCntl    (DCTxCntl),
    .DCTxData    (DCTxData),
    .DCTxWEn     (DCTxWEn),
    .DCTxRdy     (DCTxRdy),
    .TxPortCntl  (TxPortCntl),
    .TxPortData  (TxPortData),
    .TxPortWEn   (TxPortWEn),
    .TxPortRdy   (TxPortRdy),
    .HoldTimeout (HoldTimeout)
  );

  always #5 clk = ~clk;

  function automatic obs_t ob(input logic [2:0] g, input logic [2:0] r, input logic [7:0] c,
                              input logic [7:0] d, input logic w, input logic t);
    obs_t o;
    o.gnt = g; o.rdy = r; o.cntl = c; o.data = d; o.wen = w; o.to = t;
    return o;
  endfunction

  // Applies one cycle of inputs and queues the outputs expected during that cycle
  task automatic step(input logic r, input logic [2:0] req, input logic [2:0] wen,
                      input logic prdy, input obs_t e, input string nm);
    rst = r;
    {DCTxReq, SPTxReq, SOFTxReq} = req;
    {DCTxWEn, SPTxWEn, SOFTxWEn} = wen;
    TxPortRdy = prdy;
    expQ.push_back(e);
    nameQ.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    forever begin
      obs_t  e;
      obs_t  a;
      string n;
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        a = ob({DCTxGnt, SPTxGnt, SOFTxGnt}, {DCTxRdy, SPTxRdy, SOFTxRdy},
               TxPortCntl, TxPortData, TxPortWEn, HoldTimeout);
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got gnt=%b rdy=%b cntl=%h data=%h wen=%b to=%b, expected gnt=%b rdy=%b cntl=%h data=%h wen=%b to=%b",
                   n, a.gnt, a.rdy, a.cntl, a.data, a.wen, a.to,
                   e.gnt, e.rdy, e.cntl, e.data, e.wen, e.to);
        end
      end
    end
  end

  initial begin : stimulus
    obs_t idl;
    idl = ob(3'b000, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
    SOFTxCntl = SC;  SOFTxData = 8'h00;
    SPTxCntl  = SPC; SPTxData  = SPD;
    DCTxCntl  = DCC; DCTxData  = DCD;
    rst = 1'b1;
    {DCTxReq, SPTxReq, SOFTxReq} = 3'b000;
    {DCTxWEn, SPTxWEn, SOFTxWEn} = 3'b000;
    TxPortRdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    step(1, 3'b000, 3'b000, 1'b0, idl, "reset");
    // Single SOF request
    step(0, 3'b001, 3'b000, 1'b1, idl, "sofReqIdle");
    step(0, 3'b001, 3'b001, 1'b1, ob(3'b001, 3'b001, SC, 8'h00, 1'b1, 1'b0), "sofWrite");
    step(0, 3'b001, 3'b000, 1'b0, ob(3'b001, 3'b000, SC, 8'h00, 1'b0, 1'b0), "sofRdyLow");
    step(0, 3'b000, 3'b000, 1'b1, ob(3'b001, 3'b001, SC, 8'h00, 1'b0, 1'b0), "sofDrop");
    step(0, 3'b000, 3'b000, 1'b1, idl, "turnaround1");
    step(0, 3'b000, 3'b000, 1'b1, idl, "idle1");
    // SOF and SP together, SOF first, SP two cycles after the drop is seen
    step(0, 3'b011, 3'b000, 1'b1, idl, "sofSpReq");
    step(0, 3'b011, 3'b010, 1'b1, ob(3'b001, 3'b001, SC, 8'h00, 1'b0, 1'b0), "sofWinsSpWenIgnored");
    step(0, 3'b010, 3'b000, 1'b1, ob(3'b001, 3'b001, SC, 8'h00, 1'b0, 1'b0), "sofDropN");
    step(0, 3'b010, 3'b000, 1'b1, idl, "gapN1");
    step(0, 3'b010, 3'b000, 1'b1, idl, "gapN2");
    step(0, 3'b010, 3'b010, 1'b1, ob(3'b010, 3'b010, SPC, SPD, 1'b1, 1'b0), "spGrantN3");
    // SOF arrives mid-grant (no preemption); non-granted DC write must not leak
    step(0, 3'b111, 3'b100, 1'b1, ob(3'b010, 3'b010, SPC, SPD, 1'b0, 1'b0), "dcWenBlocked");
    step(0, 3'b111, 3'b110, 1'b0, ob(3'b010, 3'b000, SPC, SPD, 1'b1, 1'b0), "spWenOnly");
    step(0, 3'b101, 3'b000, 1'b1, ob(3'b010, 3'b010, SPC, SPD, 1'b0, 1'b0), "spDrop");
    step(0, 3'b101, 3'b000, 1'b1, idl, "turnaround2");
    step(0, 3'b101, 3'b000, 1'b1, idl, "sofOverDc");
    step(0, 3'b100, 3'b101, 1'b1, ob(3'b001, 3'b001, SC, 8'h00, 1'b1, 1'b0), "sofGrant2");
    step(0, 3'b100, 3'b000, 1'b1, idl, "turnaround3");
    step(0, 3'b100, 3'b000, 1'b1, idl, "dcArb");
    // DC stalls: eight granted cycles, then forced release with a pulse and a mask
    for (int i = 0; i < 8; i++)
      step(0, 3'b100, 3'b000, 1'b1, ob(3'b100, 3'b100, DCC, DCD, 1'b0, 1'b0),
           $sformatf("dcHold%0d", i));
    step(0, 3'b100, 3'b000, 1'b1, ob(3'b000, 3'b000, 8'h00, 8'h00, 1'b0, 1'b1), "timeoutPulse");
    step(0, 3'b100, 3'b000, 1'b1, idl, "dcMasked1");
    step(0, 3'b100, 3'b000, 1'b1, idl, "dcMasked2");
    step(0, 3'b000, 3'b000, 1'b1, idl, "dcReqLow");
    step(0, 3'b100, 3'b000, 1'b1, idl, "dcReqRise");
    step(0, 3'b100, 3'b100, 1'b0, ob(3'b100, 3'b000, DCC, DCD, 1'b1, 1'b0), "dcRegrant");
    // Req drop coinciding with the timeout cycle: plain release, no pulse
    for (int i = 0; i < 7; i++)
      step(0, 3'b100, 3'b000, 1'b1, ob(3'b100, 3'b100, DCC, DCD, 1'b0, 1'b0),
           $sformatf("dcHoldB%0d", i));
    step(0, 3'b000, 3'b000, 1'b1, ob(3'b100, 3'b100, DCC, DCD, 1'b0, 1'b0), "dropAtTimeout");
    step(0, 3'b000, 3'b000, 1'b1, idl, "noPulseOnDrop");
    // Reset during an SP grant
    step(0, 3'b010, 3'b000, 1'b1, idl, "spArb");
    step(0, 3'b010, 3'b010, 1'b1, ob(3'b010, 3'b010, SPC, SPD, 1'b1, 1'b0), "spGrant3");
    step(1, 3'b010, 3'b010, 1'b1, ob(3'b010, 3'b010, SPC, SPD, 1'b1, 1'b0), "rstMidGrant");
    step(0, 3'b000, 3'b000, 1'b1, idl, "afterRst");
    // Reset clears the mask left by a timeout even with req held high
    step(0, 3'b100, 3'b000, 1'b1, idl, "dcArb3");
    for (int i = 0; i < 8; i++)
      step(0, 3'b100, 3'b000, 1'b1, ob(3'b100, 3'b100, DCC, DCD, 1'b0, 1'b0),
           $sformatf("dcHoldC%0d", i));
    step(1, 3'b100, 3'b000, 1'b1, ob(3'b000, 3'b000, 8'h00, 8'h00, 1'b0, 1'b1), "rstDuringPulse");
    step(0, 3'b100, 3'b000, 1'b1, idl, "maskClearedByRst");
    step(0, 3'b000, 3'b000, 1'b1, ob(3'b100, 3'b100, DCC, DCD, 1'b0, 1'b0), "dcGrantAfterRst");
    step(0, 3'b000, 3'b000, 1'b1, idl, "turnaround4");

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hc_tx_port_arbiter.md
Name: hc_tx_port_arbiter

Overview:
Arbitrates the host controller's single SIE transmit port among three requesters: the SOF controller, the send-packet controller and the direct-line-control block.
- Each requester drives a req/gnt pair plus cntl/data/wen.
- The arbiter grants one requester at a time and muxes the granted requester's signals onto the shared Tx port.
- It returns the SIE ready only to the granted requester.
- A hold-timeout watchdog reclaims the port if a granted requester stalls.

Parameters:
MAX_HOLD, 16'd2048, maximum cycles a grant may be held without any wen pulse before forced release.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
SOFTxReq  in  1  SOF controller request
SOFTxGnt  out  1  SOF controller grant
SOFTxCntl  in  8  SOF controller Tx control code
SOFTxData  in  8  SOF controller Tx data
SOFTxWEn  in  1  SOF controller write strobe
SOFTxRdy  out  1  ready returned to SOF controller
SPTxReq/SPTxGnt/SPTxCntl/SPTxData/SPTxWEn/SPTxRdy  same shape  send-packet controller
DCTxReq/DCTxGnt/DCTxCntl/DCTxData/DCTxWEn/DCTxRdy  same shape  direct line control
TxPortCntl  out  8  to SIE Tx port
TxPortData  out  8  to SIE Tx port
TxPortWEn  out  1  to SIE Tx port
TxPortRdy  in  1  SIE Tx port ready
HoldTimeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset: clk, rst synchronous active-high. All grants 0; all Rdy outputs 0; TxPortCntl=8'h00; TxPortData=8'h00; TxPortWEn=0; HoldTimeout=0; state IDLE; hold counter 0.
- States:
  - IDLE: evaluate requests.
  - GNT_SOF, GNT_SP, GNT_DC: port owned.
  - TURNAROUND: one idle cycle after any release.
- IDLE: fixed priority SOF > SP > DC. The highest active req moves to its GNT state. The grant output is registered and asserts the cycle after the req is sampled. No req: stay in IDLE.
- GNT_x:
  - Gnt_x = 1.
  - TxPortCntl/Data/WEn = x's inputs, combinational pass-through with zero latency.
  - xTxRdy = TxPortRdy; the other Rdy outputs = 0.
  - Leave to TURNAROUND when xReq = 0 (sampled), deasserting Gnt_x the next cycle.
- Non-granted requesters: wen is ignored. They must never reach the port.
- TURNAROUND: all grants 0; TxPortWEn = 0. Next cycle goes to IDLE. Requests seen here are evaluated in IDLE, so minimum gap between grants is 2 cycles after req drop.
- Outputs outside GNT states: TxPortCntl/Data hold 8'h00; TxPortWEn = 0.
- Hold counter (16 bit):
  - Clears on entry to any GNT state and on every cycle the granted wen = 1.
  - Otherwise increments while in GNT; saturates, never wraps.
  - When it reaches MAX_HOLD: force TURNAROUND, pulse HoldTimeout for 1 cycle, drop grant.
  - Requester x is then masked from arbitration until its req has been seen low for ≥1 cycle, preventing an immediate re-grant of a stuck master.
- Priority is non-preemptive. A higher-priority req arriving during another grant waits for release.
- Simultaneous req drop and timeout in the same cycle: treat as normal release; no HoldTimeout pulse.
- Reset mid-grant: all outputs return to reset values the next edge; any in-flight SIE write is abandoned and the masks are cleared.

Decomposition:
- Shared package/header (usbHostControl_h):
  - state encodings IDLE, GNT_SOF, GNT_SP, GNT_DC, TURNAROUND;
  - requester index constants;
  - MAX_HOLD default.
- Tx control codes come from the existing SIE header.
- Natural sub-module: hc_tx_port_mux, a combinational 3:1 mux of cntl/data/wen/rdy driven by a one-hot grant vector. The FSM and counter stay in the top.

Test Plan:
- Single SOF req at cycle 0 → SOFTxGnt=1 at cycle 1. SOFTxWEn pulse with Cntl=TX_RESUME_START, Data=8'h00 appears on TxPort the same cycle. SOFTxRdy tracks TxPortRdy; SPTxRdy=DCTxRdy=0.
- SOF and SP req in the same cycle → SOF granted first. SOF drops req at cycle n → SOFTxGnt=0 at n+1, TURNAROUND, SPTxGnt=1 at n+3.
- SP granted, SOF req rises mid-grant → no preemption. SP keeps the port until its req drops, then SOF is granted.
- Non-granted DC asserts DCTxWEn with Data=8'hA5 while SP owns the port → TxPortWEn reflects only SPTxWEn; 8'hA5 never appears.
- MAX_HOLD=8, DC holds req with no wen → after 8 cycles HoldTimeout=1 for one cycle and DCTxGnt=0. DC is not re-granted until DCTxReq goes low for 1 cycle and rises again.
- rst asserted during SP grant → next edge all grants/Rdy/TxPort outputs = 0, state IDLE, masks cleared.
